axi_lite_clint_mh: RTL and testbench

- Multi-hart, fully writable AXI-Lite core-local interruptor; successor to the read-only timer peripheral.
- Provides:
  - a 64-bit mtime with programmable prescaler;
  - per-hart 64-bit mtimecmp with timer-interrupt lines;
  - per-hart software-interrupt (msip) bits.
- Sits on the peripheral crossbar; its interrupt outputs feed each core's CSR mip.MTIP/MSIP inputs.

---
 rtl/axi_lite_clint_mh_pkg.sv | 52 +++++
 rtl/axi_lite_clint_mh_stdreg.sv | 24 ++
 rtl/axi_lite_clint_mh_timer.sv | 58 +++++
 rtl/axi_lite_clint_mh.sv | 206 ++++++++++++++++++++
 tb/tb_axi_lite_clint_mh.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_clint_mh_pkg.sv
// Shared constants, decode types and byte-merge helper for the multi-hart CLINT.
// Latency: none (package only).
// Backpressure: not applicable.
package axi_lite_clint_mh_pkg;

    localparam int CPU_WIDTH = 32;
    localparam int STRB_W    = CPU_WIDTH / 8;
    localparam int MAX_HARTS = 16;

    // Register offsets inside the decoded window
    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] MTIME_HI      = 16'hBFFC;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // mtimecmp resets to the maximum so no timer interrupt fires out of reset
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_TIME_LO,
        SEL_TIME_HI
    } sel_e;

    typedef struct packed {
        sel_e       sel;
        logic [3:0] hart;
    } dec_t;

    // Replace only the byte lanes enabled in strb
    function automatic logic [CPU_WIDTH-1:0] merge_bytes(
        input logic [CPU_WIDTH-1:0] old_val,
        input logic [CPU_WIDTH-1:0] new_val,
        input logic [STRB_W-1:0]    strb
    );
        logic [CPU_WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_clint_mh_stdreg.sv
// Generic enable register with asynchronous active-low reset to a parameter value.
// Latency: 1 cycle from d_i/en_i to q_o.
// Backpressure: none; en_i low simply holds the stored value.
module stdreg #(
    parameter int             W   = 1,
    parameter logic [W-1:0]   RST = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // Storage flop, loads d_i when enabled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= RST;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/axi_lite_clint_mh_timer.sv
// Free-running 64-bit mtime with prescaler and byte-gated write override of either half.
// Latency: writes and ticks land on the next clock edge.
// Backpressure: none; a write always wins over the increment and restarts the prescaler.
module clint_timer
    import axi_lite_clint_mh_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_lo_i,
    input  logic                 wr_hi_i,
    input  logic [CPU_WIDTH-1:0] wdata_i,
    input  logic [STRB_W-1:0]    wstrb_i,
    output logic [63:0]          mtime_o
);

    localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d;
    logic          tick;

    assign tick = (presc_q == PMAX);

    // Next state: count/increment, or take the written half using pre-increment bytes
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        mtime_d = mtime_q + {63'd0, tick};
        if (wr_lo_i) begin
            presc_d = '0;
            mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wdata_i, wstrb_i)};
        end else if (wr_hi_i) begin
            presc_d = '0;
            mtime_d = {merge_bytes(mtime_q[63:32], wdata_i, wstrb_i), mtime_q[31:0]};
        end
    end

    stdreg #(.W(PW)) u_presc (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (1'b1),
        .d_i    (presc_d),
        .q_o    (presc_q)
    );

    stdreg #(.W(64)) u_mtime (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (1'b1),
        .d_i    (mtime_d),
        .q_o    (mtime_q)
    );

    assign mtime_o = mtime_q;

endmodule

// File: rtl/axi_lite_clint_mh.sv
// AXI-Lite core-local interruptor: mtime, per-hart mtimecmp/msip, registered MTIP/MSIP lines.
// Latency: read data 1 cycle after accept; write takes effect on the accept edge, IRQs 1 cycle later.
// Backpressure: one outstanding read and one outstanding write; no new accept until R/B is consumed.
module axi_lite_clint_mh
    import axi_lite_clint_mh_pkg::*;
#(
    parameter int NUM_HARTS  = 1,
    parameter int TICK_DIV   = 1,
    parameter int ADDR_LSB_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [CPU_WIDTH-1:0] awaddr,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [CPU_WIDTH-1:0] wdata,
    input  logic [STRB_W-1:0]    wstrb,
    input  logic                 wvalid,
    output logic                 wready,
    output logic [1:0]           bresp,
    output logic                 bvalid,
    input  logic                 bready,
    input  logic [CPU_WIDTH-1:0] araddr,
    input  logic                 arvalid,
    output logic                 arready,
    output logic [CPU_WIDTH-1:0] rdata,
    output logic [1:0]           rresp,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [NUM_HARTS-1:0] o_msip,
    output logic [NUM_HARTS-1:0] o_mtip
);

    // Offset decode; misaligned offsets and harts beyond NUM_HARTS are unmapped
    function automatic dec_t decode(input logic [ADDR_LSB_W-1:0] off);
        dec_t                  d;
        logic [ADDR_LSB_W-1:0] rel_msip;
        logic [ADDR_LSB_W-1:0] rel_cmp;
        d.sel    = SEL_NONE;
        d.hart   = '0;
        rel_msip = off - ADDR_LSB_W'(MSIP_BASE);
        rel_cmp  = off - ADDR_LSB_W'(MTIMECMP_BASE);
        if (off[1:0] == 2'b00) begin
            if (off == ADDR_LSB_W'(MTIME_LO)) begin
                d.sel = SEL_TIME_LO;
            end else if (off == ADDR_LSB_W'(MTIME_HI)) begin
                d.sel = SEL_TIME_HI;
            end else if (rel_msip < ADDR_LSB_W'(4 * NUM_HARTS)) begin
                d.sel  = SEL_MSIP;
                d.hart = rel_msip[5:2];
            end else if (rel_cmp < ADDR_LSB_W'(8 * NUM_HARTS)) begin
                d.sel  = rel_cmp[2] ? SEL_CMP_HI : SEL_CMP_LO;
                d.hart = rel_cmp[6:3];
            end
        end
        return d;
    endfunction

    dec_t ar_dec, aw_dec;
    logic ar_acc, aw_acc, wr_any;
    logic unused_addr_hi;

    assign ar_dec = decode(araddr[ADDR_LSB_W-1:0]);
    assign aw_dec = decode(awaddr[ADDR_LSB_W-1:0]);
    // Bits above the decoded window are ignored
    assign unused_addr_hi = ^{araddr[CPU_WIDTH-1:ADDR_LSB_W], awaddr[CPU_WIDTH-1:ADDR_LSB_W]};
    assign wr_any = |wstrb;

    logic                 arready_q, rvalid_q, awready_q, bvalid_q;
    logic [CPU_WIDTH-1:0] rdata_q;
    logic [1:0]           rresp_q, bresp_q;

    // AW and W are only taken together, and only when the B slot is free
    assign ar_acc = arvalid && !arready_q && (!rvalid_q || rready);
    assign aw_acc = awvalid && wvalid && !awready_q && (!bvalid_q || bready);

    // Register file: unused hart slots are tied to reset values so the
    // 4-bit hart index always addresses a full 16-entry array
    logic [MAX_HARTS-1:0] msip_q;
    logic [31:0]          cmp_lo_q [MAX_HARTS];
    logic [31:0]          cmp_hi_q [MAX_HARTS];
    logic [63:0]          mtime;
    logic [NUM_HARTS-1:0] msip_out_q, mtip_out_q;

    for (genvar h = 0; h < MAX_HARTS; h++) begin : g_hart
        if (h < NUM_HARTS) begin : g_real
            logic hit;
            assign hit = aw_acc && (aw_dec.hart == 4'(h));

            stdreg #(.W(1)) u_msip (
                .clk_i  (i_clk),
                .rst_ni (i_rst_n),
                .en_i   (hit && (aw_dec.sel == SEL_MSIP) && wstrb[0]),
                .d_i    (wdata[0]),
                .q_o    (msip_q[h])
            );

            stdreg #(.W(32), .RST(MTIMECMP_RST[31:0])) u_cmp_lo (
                .clk_i  (i_clk),
                .rst_ni (i_rst_n),
                .en_i   (hit && (aw_dec.sel == SEL_CMP_LO) && wr_any),
                .d_i    (merge_bytes(cmp_lo_q[h], wdata, wstrb)),
                .q_o    (cmp_lo_q[h])
            );

            stdreg #(.W(32), .RST(MTIMECMP_RST[63:32])) u_cmp_hi (
                .clk_i  (i_clk),
                .rst_ni (i_rst_n),
                .en_i   (hit && (aw_dec.sel == SEL_CMP_HI) && wr_any),
                .d_i    (merge_bytes(cmp_hi_q[h], wdata, wstrb)),
                .q_o    (cmp_hi_q[h])
            );

            // Interrupt lines are registered one cycle behind the state they reflect
            stdreg #(.W(1)) u_mtip (
                .clk_i  (i_clk),
                .rst_ni (i_rst_n),
                .en_i   (1'b1),
                .d_i    (mtime >= {cmp_hi_q[h], cmp_lo_q[h]}),
                .q_o    (mtip_out_q[h])
            );

            stdreg #(.W(1)) u_msip_out (
                .clk_i  (i_clk),
                .rst_ni (i_rst_n),
                .en_i   (1'b1),
                .d_i    (msip_q[h]),
                .q_o    (msip_out_q[h])
            );
        end else begin : g_tie
            assign msip_q[h]   = 1'b0;
            assign cmp_lo_q[h] = MTIMECMP_RST[31:0];
            assign cmp_hi_q[h] = MTIMECMP_RST[63:32];
        end
    end

    clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .wr_lo_i (aw_acc && (aw_dec.sel == SEL_TIME_LO) && wr_any),
        .wr_hi_i (aw_acc && (aw_dec.sel == SEL_TIME_HI) && wr_any),
        .wdata_i (wdata),
        .wstrb_i (wstrb),
        .mtime_o (mtime)
    );

    logic [CPU_WIDTH-1:0] rd_dat;
    logic [1:0]           rd_resp, wr_resp;

    assign wr_resp = (aw_dec.sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;

    // Read mux over current (pre-write) register values
    always_comb begin
        rd_dat  = '0;
        rd_resp = RESP_OKAY;
        case (ar_dec.sel)
            SEL_MSIP:    rd_dat = {31'd0, msip_q[ar_dec.hart]};
            SEL_CMP_LO:  rd_dat = cmp_lo_q[ar_dec.hart];
            SEL_CMP_HI:  rd_dat = cmp_hi_q[ar_dec.hart];
            SEL_TIME_LO: rd_dat = mtime[31:0];
            SEL_TIME_HI: rd_dat = mtime[63:32];
            default:     rd_resp = RESP_SLVERR;
        endcase
    end

    // AXI handshake and response holding registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            arready_q <= ar_acc;
            if (ar_acc) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_dat;
                rresp_q  <= rd_resp;
            end else if (rready) begin
                rvalid_q <= 1'b0;
            end
            awready_q <= aw_acc;
            if (aw_acc) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign awready = awready_q;
    assign wready  = awready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign o_msip  = msip_out_q;
    assign o_mtip  = mtip_out_q;

endmodule

// File: tb/tb_axi_lite_clint_mh.sv
module tb_axi_lite_clint_mh;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [1:0]  o_msip, o_mtip;

    int n_assert = 0;
    int n_fail   = 0;

    axi_lite_clint_mh #(.NUM_HARTS(2), .TICK_DIV(4), .ADDR_LSB_W(16)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .o_msip  (o_msip),
        .o_mtip  (o_mtip)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns 1 unit after the edge two cycles later
    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        n = 0;
        araddr  = a;
        arvalid = 1'b1;
        do begin
            @(posedge i_clk);
            #1;
            n++;
        end while (!arready && n < 20);
        check("ar_handshake", {62'd0, arready, rvalid}, 64'h3);
        d       = rdata;
        r       = rresp;
        arvalid = 1'b0;
        rready  = 1'b1;
        @(posedge i_clk);
        #1;
        rready = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] strb,
                             output logic [1:0] r, output logic [1:0] mtip_at_b);
        int n;
        n = 0;
        awaddr  = a;
        wdata   = dat;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        do begin
            @(posedge i_clk);
            #1;
            n++;
        end while (!awready && n < 20);
        check("aw_handshake", {61'd0, awready, wready, bvalid}, 64'h7);
        r         = bresp;
        mtip_at_b = o_mtip;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b1;
        @(posedge i_clk);
        #1;
        bready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [1:0]  mb;

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_handshake", {59'd0, awready, wready, arready, bvalid, rvalid}, 64'h0);
        check("reset_data", {24'd0, rdata, bresp, rresp, o_msip, o_mtip}, 64'h0);

        // mtime counts from 0, one tick every 4 cycles
        i_rst_n = 1'b1;
        axi_read(32'h0000_BFF8, d, r);
        check("mtime_lo_first", d, 64'h0);
        check("mtime_lo_first_resp", r, 64'h0);
        axi_read(32'h0000_BFFC, d, r);
        check("mtime_hi_first", d, 64'h0);
        wait_cycles(10);
        axi_read(32'h0000_BFF8, d, r);
        check("mtime_lo_later", d, 64'h3);

        // mtime write, prescaler restart and carry into the high half
        axi_write(32'h0000_BFF8, 32'hFFFF_FFFE, 4'hF, r, mb);
        check("mtime_lo_wr_resp", r, 64'h0);
        axi_write(32'h0000_BFFC, 32'h0, 4'hF, r, mb);
        check("mtime_hi_wr_resp", r, 64'h0);
        wait_cycles(6);
        axi_read(32'h0000_BFF8, d, r);
        check("mtime_pre_carry", d, 64'hFFFF_FFFF);
        wait_cycles(3);
        axi_read(32'h0000_BFF8, d, r);
        check("mtime_carry_lo", d, 64'h1);
        axi_read(32'h0000_BFFC, d, r);
        check("mtime_carry_hi", d, 64'h1);

        // mtimecmp[1] = 0x1_0000_0010, reached 14 ticks later
        axi_write(32'h0000_4008, 32'h10, 4'hF, r, mb);
        check("cmp1_lo_resp", r, 64'h0);
        axi_write(32'h0000_400C, 32'h1, 4'hF, r, mb);
        check("mtip_after_cmp_wr", o_mtip, 64'h0);
        wait_cycles(52);
        check("mtip_before_match", o_mtip, 64'h0);
        wait_cycles(1);
        check("mtip_at_match", o_mtip, 64'h2);
        axi_read(32'h0000_400C, d, r);
        check("cmp1_hi_read", d, 64'h1);
        axi_read(32'h0000_4008, d, r);
        check("cmp1_lo_read", d, 64'h10);
        axi_write(32'h0000_400C, 32'hFFFF_FFFF, 4'hF, r, mb);
        check("mtip_still_high_at_b", mb, 64'h2);
        check("mtip_cleared", o_mtip, 64'h0);

        // Software interrupts and byte strobes
        axi_write(32'h0000_0004, 32'h1, 4'h1, r, mb);
        check("msip1_set", o_msip, 64'h2);
        axi_write(32'h0000_0004, 32'h0, 4'h0, r, mb);
        check("strb0_resp", r, 64'h0);
        check("strb0_no_change", o_msip, 64'h2);
        axi_write(32'h0000_0000, 32'hFFFF_FFFF, 4'hE, r, mb);
        check("msip0_lane0_off", o_msip, 64'h2);
        axi_read(32'h0000_0004, d, r);
        check("msip1_read", {30'd0, r, d}, 64'h1);

        // Unmapped accesses
        axi_read(32'h0000_8000, d, r);
        check("unmapped_read", {30'd0, r, d}, 64'h2_0000_0000);
        axi_write(32'h0000_0008, 32'h1, 4'hF, r, mb);
        check("unmapped_write_resp", r, 64'h2);
        check("unmapped_write_no_change", o_msip, 64'h2);
        axi_read(32'h0000_4010, d, r);
        check("cmp_h2_read", {30'd0, r, d}, 64'h2_0000_0000);

        // Same-cycle read and write of msip0, then hold responses with new requests pending
        araddr  = 32'h0000_0000;
        arvalid = 1'b1;
        awaddr  = 32'h0000_0000;
        wdata   = 32'h1;
        wstrb   = 4'h1;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        wait_cycles(1);
        check("dual_accept", {59'd0, arready, awready, wready, rvalid, bvalid}, 64'h1F);
        check("read_sees_pre_write", {28'd0, rresp, bresp, rdata}, 64'h0);
        araddr = 32'h0000_0004;
        awaddr = 32'h0000_0004;
        wdata  = 32'h0;
        for (int i = 0; i < 5; i++) begin
            wait_cycles(1);
            check("held_no_accept", {59'd0, arready, awready, wready, rvalid, bvalid}, 64'h3);
        end
        check("held_msip", o_msip, 64'h3);
        check("held_rdata", rdata, 64'h0);

        // Reset while responses are pending
        i_rst_n = 1'b0;
        #1;
        check("midreset_handshake", {59'd0, awready, wready, arready, bvalid, rvalid}, 64'h0);
        check("midreset_irq", {60'd0, o_msip, o_mtip}, 64'h0);
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wait_cycles(2);
        i_rst_n = 1'b1;
        axi_read(32'h0000_BFF8, d, r);
        check("post_reset_mtime", d, 64'h0);
        axi_read(32'h0000_0000, d, r);
        check("post_reset_msip0", d, 64'h0);
        axi_read(32'h0000_400C, d, r);
        check("post_reset_cmp1_hi", d, 64'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
